// File: rtl/nibble_serial_subtractor_32bit_if.sv
// Start/busy/done handshake bundle for the nibble-serial subtractor.
// Flag signals exist only when SUB_FLAGS_EN is defined.
interface nibble_serial_subtractor_32bit_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        b_out;
`ifdef SUB_FLAGS_EN
  logic        zero;
  logic        negative;
  logic        overflow;

  modport master (output start, a, b, b_in,
                  input  busy, done, d, b_out, zero, negative, overflow);
  modport slave  (input  start, a, b, b_in,
                  output busy, done, d, b_out, zero, negative, overflow);
`else
  modport master (output start, a, b, b_in,
                  input  busy, done, d, b_out);
  modport slave  (input  start, a, b, b_in,
                  output busy, done, d, b_out);
`endif
endinterface

// File: rtl/nibble_serial_subtractor_32bit.sv
// Multi-cycle 32-bit subtractor d = a - b - b_in, one nibble per clock, borrow
// rippling between cycles. Optional zero/negative/overflow flags: SUB_FLAGS_EN.
module nibble_serial_subtractor_32bit (
  input  logic                            clk,
  input  logic                            reset,
  nibble_serial_subtractor_32bit_if.slave bus
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned NibW   = 4;
  localparam int unsigned StepW  = 3;
  localparam int unsigned LastK  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [StepW-1:0]   k_q;
  logic [DataW-1:0]   a_q;
  logic [DataW-1:0]   b_q;
  logic               borrow_q;
  logic [DataW-1:0]   part_q;
  logic [DataW-1:0]   d_q;
  logic               b_out_q;
  logic               busy_q;
  logic               done_q;
`ifdef SUB_FLAGS_EN
  logic               zero_q;
  logic               negative_q;
  logic               overflow_q;
`endif

  logic [4:0]         nib_lsb_c;
  logic [NibW-1:0]    a_nib_c;
  logic [NibW-1:0]    b_nib_c;
  logic [NibW:0]      diff_c;
  logic [DataW-1:0]   result_c;
  logic               accept_c;

  // Current nibble step; diff_c[4] is the borrow out of this nibble.
  always_comb begin
    nib_lsb_c = {k_q, 2'b00};
    a_nib_c   = a_q[nib_lsb_c +: NibW];
    b_nib_c   = b_q[nib_lsb_c +: NibW];
    diff_c    = {1'b0, a_nib_c} - {1'b0, b_nib_c} - 5'(borrow_q);
    result_c  = {diff_c[NibW-1:0], part_q[DataW-NibW-1:0]};
    accept_c  = bus.start && (state_q != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      borrow_q   <= 1'b0;
      part_q     <= '0;
      d_q        <= '0;
      b_out_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          part_q[nib_lsb_c +: NibW] <= diff_c[NibW-1:0];
          borrow_q                  <= diff_c[NibW];
          k_q                       <= StepW'(k_q + 3'd1);
          if (k_q == StepW'(LastK)) begin
            d_q     <= result_c;
            b_out_q <= diff_c[NibW];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
`ifdef SUB_FLAGS_EN
            zero_q     <= (result_c == '0);
            negative_q <= result_c[DataW-1];
            overflow_q <= (a_q[DataW-1] != b_q[DataW-1]) &&
                          (result_c[DataW-1] != a_q[DataW-1]);
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE lasts one cycle.
          if (accept_c) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.b_in;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.d     = d_q;
  assign bus.b_out = b_out_q;
`ifdef SUB_FLAGS_EN
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor_32bit.sv
// Scoreboard bench for nibble_serial_subtractor_32bit: directed operations push
// hand-computed results; a done-driven monitor pops and compares them.
module tb_nibble_serial_subtractor_32bit;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  logic [31:0] prev_d;
  exp_t exp_q[$];

  nibble_serial_subtractor_32bit_if bus();

  nibble_serial_subtractor_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h required=none", bus.d);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("d", bus.d, e.d);
        chk("b_out", 32'(bus.b_out), 32'(e.bo));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef SUB_FLAGS_EN
        chk("zero", 32'(bus.zero), 32'(e.z));
        chk("negative", 32'(bus.negative), 32'(e.n));
        chk("overflow", 32'(bus.overflow), 32'(e.o));
`endif
        prev_d = e.d;
      end
    end
  end

  // Called right after a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi,
                       input logic [31:0] d, input logic bo,
                       input logic z, input logic n, input logic o);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bi;
    @(posedge clk);
    #1;
    e.d = d; e.bo = bo; e.z = z; e.n = n; e.o = o; e.cyc = cyc + 8;
    exp_q.push_back(e);
    bus.start = 1'b0;
  endtask

  // Waits for done; checks busy and held d on every cycle of the run.
  task automatic wait_done(input int bound);
    int  i;
    bit  busy_ok;
    bit  hold_ok;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.d !== prev_d) hold_ok = 1'b0;
    end
    if (i == bound) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=<%0d", i, bound);
    end
    chk("busy_during_run", 32'(busy_ok), 32'd1);
    chk("d_held_during_run", 32'(hold_ok), 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    prev_d    = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d", bus.d, 32'd0);
    chk("rst_b_out", 32'(bus.b_out), 32'd0);
    reset = 1'b0;

    @(negedge clk);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(20);

    @(negedge clk);
    issue(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done(20);

    @(negedge clk);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(20);

    // Back-to-back: second issue in the done cycle, done 9 cycles later.
    @(negedge clk);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done(20);
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done(20);

    // start and operand changes during RUN must be ignored.
    @(negedge clk);
    issue(32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'h0000_0000;
    bus.b_in  = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hA5A5_A5A5;
    bus.b     = 32'h5A5A_5A5A;
    wait_done(20);

    // Asynchronous reset mid-run: outputs clear at once, no done pulse.
    @(negedge clk);
    issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFE_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_d", bus.d, 32'd0);
    chk("mid_rst_b_out", 32'(bus.b_out), 32'd0);
    void'(exp_q.pop_back());
    prev_d = '0;
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hCC79_6876, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(20);

    @(negedge clk);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(20);

    repeat (12) @(negedge clk);
    chk("final_d_hold", bus.d, 32'h8000_0000);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
